// File: rtl/vdu_char_ram_arb_if.sv
// +----------------------------------------------------------------------------+
// | Module : vdu_char_ram_arb_if                                               |
// | Brief  : Bundle of display, CPU, clear-engine and RAM signals for the VDU   |
// |          character RAM arbiter.                                             |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface vdu_char_ram_arb_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              cpu_stb;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_starve;

  logic              clr_start;
  logic [DATA_W-1:0] clr_data;
  logic              clr_busy;
  logic              clr_done;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_stb, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_data, ram_rdata,
    output disp_data, disp_valid, cpu_rdata, cpu_ack, cpu_starve,
           clr_busy, clr_done, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_stb, cpu_we, cpu_addr, cpu_wdata,
           clr_start, clr_data, ram_rdata,
    input  disp_data, disp_valid, cpu_rdata, cpu_ack, cpu_starve,
           clr_busy, clr_done, ram_we, ram_addr, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/vdu_char_ram_arb.sv
// +----------------------------------------------------------------------------+
// | Module : vdu_char_ram_arb                                                  |
// | Brief  : Fixed-priority arbiter (display > CPU > clear engine) for the      |
// |          single-port VDU character RAM, with CPU FSM and fill engine.       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module vdu_char_ram_arb #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 8,
  parameter int CPU_MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  vdu_char_ram_arb_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_ACK     = 2'd2
  } cpu_state_t;

  localparam logic [3:0] c_max_wait = 4'(CPU_MAX_WAIT);

  cpu_state_t        r_state;
  logic [3:0]        r_wait;
  logic              r_disp_valid;
  logic              r_cpu_ack;
  logic              r_starve;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic [DATA_W-1:0] r_fill;
  logic [ADDR_W-1:0] r_clr_cnt;

  logic              w_cpu_gnt;
  logic              w_clr_gnt;
  logic              w_clr_last;
  logic [3:0]        w_wait_inc;

  assign w_cpu_gnt  = !bus.disp_req && (r_state == S_IDLE) && bus.cpu_stb;
  assign w_clr_gnt  = !bus.disp_req && !w_cpu_gnt && r_clr_busy;
  assign w_clr_last = &r_clr_cnt;
  assign w_wait_inc = (r_wait == 4'hF) ? r_wait : r_wait + 4'd1;

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (bus.disp_req) begin
      bus.ram_addr = bus.disp_addr;
    end else if (w_cpu_gnt) begin
      bus.ram_we   = bus.cpu_we;
      bus.ram_addr = bus.cpu_addr;
      if (bus.cpu_we) bus.ram_wdata = bus.cpu_wdata;
    end else if (w_clr_gnt) begin
      bus.ram_we    = 1'b1;
      bus.ram_addr  = r_clr_cnt;
      bus.ram_wdata = r_fill;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_wait       <= 4'd0;
      r_disp_valid <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_starve     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
      r_fill       <= '0;
      r_clr_cnt    <= '0;
    end else begin
      r_disp_valid <= bus.disp_req;
      r_cpu_ack    <= 1'b0;
      r_clr_done   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_cpu_gnt) begin
            if (bus.cpu_we) begin
              r_state   <= S_ACK;
              r_cpu_ack <= 1'b1;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          r_cpu_rdata <= bus.ram_rdata;
          r_cpu_ack   <= 1'b1;
          r_state     <= S_ACK;
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // Only a request stuck in IDLE behind the display counts as blocked.
      if (!bus.cpu_stb || w_cpu_gnt) begin
        r_wait <= 4'd0;
      end else if (r_state == S_IDLE) begin
        r_wait <= w_wait_inc;
        if (w_wait_inc >= c_max_wait) r_starve <= 1'b1;
      end

      if (bus.clr_start && !r_clr_busy) begin
        r_fill     <= bus.clr_data;
        r_clr_cnt  <= '0;
        r_clr_busy <= 1'b1;
      end else if (w_clr_gnt) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
        if (w_clr_last) begin
          r_clr_busy <= 1'b0;
          r_clr_done <= 1'b1;
        end
      end
    end
  end

  assign bus.disp_valid = r_disp_valid;
  assign bus.disp_data  = bus.ram_rdata;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.cpu_starve = r_starve;
  assign bus.clr_busy   = r_clr_busy;
  assign bus.clr_done   = r_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_vdu_char_ram_arb.sv
// +----------------------------------------------------------------------------+
// | Module : tb_vdu_char_ram_arb                                               |
// | Brief  : Table, directed and random checks of the character RAM arbiter     |
// |          against a cycle-level reference model and a local RAM.             |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_vdu_char_ram_arb;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int DEPTH = 2048;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vdu_char_ram_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  vdu_char_ram_arb #(.ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Character RAM: synchronous write, registered read address.
  logic [7:0]  ram [0:DEPTH-1];
  logic [10:0] ram_addr_q;
  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
    ram_addr_q <= bus.ram_addr;
  end
  assign bus.ram_rdata = ram[ram_addr_q];

  int total = 0;
  int bad   = 0;

  // Reference model state: expected memory image plus expected outputs.
  logic [7:0] mm [0:DEPTH-1];
  bit         mk [0:DEPTH-1];
  bit         mvalid = 0;
  int         cbusy = 0;
  bit         e_ack = 0, e_rdk = 0, pendk = 0;
  logic [7:0] e_rdata = 0, pend = 0;
  int         waitc = 0;
  bit         e_starve = 0;
  bit         m_clr = 0, e_done = 0;
  int         m_ptr = 0;
  logic [7:0] m_fill = 0;
  bit         e_dv = 0, e_ddk = 0;
  logic [7:0] e_dd = 0;

  typedef struct {
    bit          d;
    bit          s;
    bit          w;
    logic [10:0] da;
    logic [10:0] ca;
    logic [7:0]  wd;
    bit          ewe;
    logic [10:0] ea;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    bus.disp_req  = 0; bus.disp_addr = '0;
    bus.cpu_stb   = 0; bus.cpu_we    = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 0; bus.clr_data  = '0;
  endtask

  // Mid-cycle: check outputs against the model, then advance the model.
  task automatic half();
    bit g_d, g_c, g_k, x_we, free;
    int x_addr, x_wd;
    @(negedge clk);
    if (mvalid) begin
      chk("disp_valid", bus.disp_valid, e_dv);
      if (e_dv && e_ddk) chk("disp_data", bus.disp_data, e_dd);
      chk("cpu_ack", bus.cpu_ack, e_ack);
      if (e_rdk) chk("cpu_rdata", bus.cpu_rdata, e_rdata);
      chk("cpu_starve", bus.cpu_starve, e_starve);
      chk("clr_busy", bus.clr_busy, m_clr);
      chk("clr_done", bus.clr_done, e_done);
      free   = (cbusy == 0);
      g_d    = bus.disp_req;
      g_c    = !g_d && free && bus.cpu_stb;
      g_k    = !g_d && !g_c && m_clr;
      x_we   = (g_c && bus.cpu_we) || g_k;
      x_addr = g_d ? int'(bus.disp_addr) : g_c ? int'(bus.cpu_addr) : g_k ? m_ptr : 0;
      x_wd   = g_c ? int'(bus.cpu_wdata) : g_k ? int'(m_fill) : 0;
      chk("ram_we", bus.ram_we, x_we);
      chk("ram_addr", bus.ram_addr, x_addr);
      if (x_we || !(g_d || g_c || g_k)) chk("ram_wdata", bus.ram_wdata, x_wd);

      e_dv  = g_d;
      e_dd  = mm[bus.disp_addr];
      e_ddk = mk[bus.disp_addr];
      e_ack = 0;
      if (g_c) begin
        if (bus.cpu_we) begin
          e_ack = 1; cbusy = 1;
        end else begin
          pend = mm[bus.cpu_addr]; pendk = mk[bus.cpu_addr]; cbusy = 2;
        end
      end else if (cbusy == 2) begin
        e_ack = 1; e_rdata = pend; e_rdk = pendk; cbusy = 1;
      end else if (cbusy == 1) begin
        cbusy = 0;
      end
      if (!bus.cpu_stb || g_c) waitc = 0;
      else if (free) begin
        waitc = (waitc < 15) ? waitc + 1 : 15;
        if (waitc >= 15) e_starve = 1;
      end
      e_done = 0;
      if (bus.clr_start && !m_clr) begin
        m_clr = 1; m_ptr = 0; m_fill = bus.clr_data;
      end else if (g_k) begin
        if (m_ptr == DEPTH - 1) begin
          m_clr = 0; e_done = 1;
        end
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      if (x_we) begin
        mm[x_addr] = 8'(x_wd); mk[x_addr] = 1;
      end
    end
    if (!rst) begin
      mvalid = 1; e_dv = 0; e_ack = 0; e_rdata = 0; e_rdk = 1; e_starve = 0;
      m_clr = 0; m_ptr = 0; e_done = 0; cbusy = 0; waitc = 0;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half();
    adv();
  endtask

  task automatic cpu_xfer(input bit we, input logic [10:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
    bit got;
    got = 0;
    rd  = '0;
    bus.cpu_stb = 1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    for (int n = 0; n < 20 && !got; n++) begin
      half();
      if (bus.cpu_ack) begin
        got = 1; rd = bus.cpu_rdata;
      end
      adv();
    end
    bus.cpu_stb = 0;
    chk("cpu_xfer_ack", got, 1);
  endtask

  initial begin
    logic [7:0] rd;
    int errs;
    bit done_seen, ack;

    tbl[0] = '{0, 0, 0, 11'h000, 11'h000, 8'h00, 0, 11'h000};
    tbl[1] = '{1, 0, 0, 11'h123, 11'h000, 8'h00, 0, 11'h123};
    tbl[2] = '{0, 1, 1, 11'h000, 11'h0AA, 8'h5C, 1, 11'h0AA};
    tbl[3] = '{0, 1, 0, 11'h000, 11'h0AA, 8'h00, 0, 11'h0AA};
    tbl[4] = '{1, 1, 1, 11'h001, 11'h300, 8'h11, 0, 11'h001};
    tbl[5] = '{0, 1, 1, 11'h000, 11'h000, 8'hFF, 1, 11'h000};
    tbl[6] = '{1, 0, 0, 11'h0AA, 11'h000, 8'h00, 0, 11'h0AA};
    tbl[7] = '{0, 1, 1, 11'h000, 11'h7FF, 8'h3C, 1, 11'h7FF};

    idle_in();
    rst = 0;
    repeat (3) cyc();
    rst = 1;
    for (int i = 0; i < 10; i++) begin
      half();
      chk("rst_ram_we", bus.ram_we, 0);
      chk("rst_outs", {bus.disp_valid, bus.cpu_ack, bus.cpu_starve, bus.clr_busy,
                       bus.clr_done, bus.cpu_rdata}, 0);
      adv();
    end

    // Grant priority from an idle arbiter.
    for (int i = 0; i < 8; i++) begin
      bus.disp_req = tbl[i].d; bus.disp_addr = tbl[i].da;
      bus.cpu_stb = tbl[i].s; bus.cpu_we = tbl[i].w;
      bus.cpu_addr = tbl[i].ca; bus.cpu_wdata = tbl[i].wd;
      half();
      chk("tbl_we", bus.ram_we, tbl[i].ewe);
      chk("tbl_addr", bus.ram_addr, tbl[i].ea);
      if (tbl[i].ewe) chk("tbl_wdata", bus.ram_wdata, tbl[i].wd);
      adv();
      idle_in();
      repeat (3) cyc();
    end

    // CPU write then read of 0x155.
    bus.cpu_stb = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h155; bus.cpu_wdata = 8'hA5;
    half();
    chk("wr_grant_we", bus.ram_we, 1);
    chk("wr_grant_addr", bus.ram_addr, 11'h155);
    adv();
    half(); chk("wr_ack_n1", bus.cpu_ack, 1); adv();
    bus.cpu_stb = 1; bus.cpu_we = 0;
    half(); chk("rd_grant_we", bus.ram_we, 0); chk("rd_grant_addr", bus.ram_addr, 11'h155); adv();
    half(); chk("rd_ack_n1", bus.cpu_ack, 0); adv();
    half(); chk("rd_ack_n2", bus.cpu_ack, 1); chk("rd_data", bus.cpu_rdata, 8'hA5); adv();
    idle_in();
    cyc();

    // Display hogs the port for 20 cycles while the CPU waits.
    bus.cpu_stb = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h042; bus.cpu_wdata = 8'h99;
    for (int i = 0; i < 20; i++) begin
      bus.disp_req = 1; bus.disp_addr = 11'($urandom);
      half();
      chk("starve_blocked_addr", bus.ram_addr, bus.disp_addr);
      if (i > 0) chk("starve_disp_valid", bus.disp_valid, 1);
      if (i == 14) chk("starve_not_yet", bus.cpu_starve, 0);
      if (i == 15) chk("starve_set", bus.cpu_starve, 1);
      adv();
    end
    bus.disp_req = 0;
    half(); chk("release_we", bus.ram_we, 1); chk("release_addr", bus.ram_addr, 11'h042); adv();
    half(); chk("release_ack", bus.cpu_ack, 1); adv();
    idle_in();
    cyc();

    // Quiet clear with 0x20.
    bus.clr_start = 1; bus.clr_data = 8'h20;
    cyc();
    bus.clr_start = 0;
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      half();
      if (!(bus.ram_we === 1'b1 && bus.ram_addr === 11'(i) && bus.ram_wdata === 8'h20)) errs++;
      adv();
    end
    chk("clr_seq_errs", errs, 0);
    half(); chk("clr_done_2049", bus.clr_done, 1); chk("clr_busy_end", bus.clr_busy, 0); adv();
    half(); chk("clr_done_pulse", bus.clr_done, 0); adv();
    for (int k = 0; k <= 16; k++) begin
      bus.disp_req = (k < 16); bus.disp_addr = 11'($urandom);
      half();
      if (k > 0) chk("clr_rd", bus.disp_data, 8'h20);
      adv();
    end
    idle_in();
    cyc();

    // Clear under random display/CPU traffic with an early write to 0x7FF.
    bus.clr_start = 1; bus.clr_data = 8'h20;
    cyc();
    bus.clr_start = 0;
    cpu_xfer(1, 11'h7FF, 8'h5A, rd);
    done_seen = 0;
    for (int c = 0; c < 12000; c++) begin
      bus.disp_req  = 1'($urandom);
      bus.disp_addr = 11'($urandom);
      bus.clr_start = (c < 1000) && ($urandom_range(63) == 0);
      bus.clr_data  = 8'($urandom);
      if (!bus.cpu_stb && !done_seen && $urandom_range(5) == 0) begin
        bus.cpu_stb   = 1;
        bus.cpu_we    = 1'($urandom);
        bus.cpu_addr  = 11'($urandom_range(11'h7EF));
        bus.cpu_wdata = 8'($urandom);
      end
      half();
      ack = bus.cpu_ack;
      if (bus.clr_done) done_seen = 1;
      adv();
      if (ack) bus.cpu_stb = 0;
      if (done_seen && !bus.cpu_stb) break;
    end
    chk("rnd_clear_done", done_seen, 1);
    idle_in();
    cyc();
    cpu_xfer(0, 11'h7FF, 8'h00, rd);
    chk("rd_7ff_after_clr", rd, 8'h20);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) if (!mk[i] || ram[i] !== mm[i]) errs++;
    chk("ram_image_errs", errs, 0);

    // Reset during a CPU read wait and in the middle of a clear.
    bus.clr_start = 1; bus.clr_data = 8'h33;
    cyc();
    bus.clr_start = 0;
    repeat (100) cyc();
    bus.cpu_stb = 1; bus.cpu_we = 0; bus.cpu_addr = 11'h010;
    half(); chk("rst_rd_grant", bus.ram_addr, 11'h010); adv();
    rst = 0;
    half(); adv();
    rst = 1;
    bus.cpu_stb = 0;
    half();
    chk("rst_no_ack", bus.cpu_ack, 0);
    chk("rst_clr_busy", bus.clr_busy, 0);
    chk("rst_starve_clr", bus.cpu_starve, 0);
    adv();
    for (int i = 0; i < 3; i++) begin
      half(); chk("rst_no_late_ack", bus.cpu_ack, 0); adv();
    end
    bus.cpu_stb = 1; bus.cpu_we = 1; bus.cpu_addr = 11'h020; bus.cpu_wdata = 8'h77;
    half(); chk("rst_idle_grant", bus.ram_we, 1); adv();
    half(); chk("rst_idle_ack", bus.cpu_ack, 1); adv();
    idle_in();
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
